// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types for the pipelined MIPS core.
package cpu_types_pkg;
  typedef logic [4:0] regbits_t;
endpackage

// File: rtl/fwd_hazard_pkg.sv
// Types and helpers for the forwarding/hazard scoreboard.
package fwd_hazard_pkg;
  import cpu_types_pkg::*;

  typedef struct packed {
    logic     valid;
    regbits_t dst;
    logic     is_load;
  } fwd_slot_t;

  localparam int READY_ALU = 1;

  // First slot index at which a producer's result can be forwarded.
  function automatic int ready_slot(input logic is_load, input int load_lat);
    return is_load ? (READY_ALU + load_lat) : READY_ALU;
  endfunction
endpackage

// File: rtl/fwd_match.sv
// Youngest-producer lookup for one ID operand against the slot scoreboard.
module fwd_match
  import cpu_types_pkg::*;
  import fwd_hazard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int SELW     = $clog2(DEPTH)
) (
  input  fwd_slot_t [DEPTH-1:0] slots,
  input  regbits_t              rreg,
  input  logic                  use_r,
  output logic                  hit,
  output logic [SELW-1:0]       sel,
  output logic                  not_ready
);

  // Scan oldest to youngest so the lowest-index match wins.
  always_comb begin
    hit       = 1'b0;
    sel       = '0;
    not_ready = 1'b0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (use_r && (rreg != '0) && slots[k].valid && (slots[k].dst == rreg)) begin
        hit       = (k + 1 <= DEPTH - 1);
        sel       = (k + 1 <= DEPTH - 1) ? SELW'(k + 1) : '0;
        not_ready = (k + 1 < ready_slot(slots[k].is_load, LOAD_LAT));
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select / load-use stall unit over a DEPTH-slot writer scoreboard.
// Optional stall-cycle counter enabled by defining FWD_HAZARD_PERF_EN.
module fwd_hazard_unit
  import cpu_types_pkg::*;
  import fwd_hazard_pkg::*;
#(
  parameter int  DEPTH    = 3,
  parameter int  LOAD_LAT = 1,
  localparam int SELW     = $clog2(DEPTH)
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            pipe_en,
  input  logic            flush,
  input  regbits_t        id_rs,
  input  regbits_t        id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            id_wen,
  input  regbits_t        id_dst,
  input  logic            id_load,
  output logic            stall,
  output logic [SELW-1:0] ex_asel,
  output logic [SELW-1:0] ex_bsel,
  output logic [31:0]     stall_cycles
);

  fwd_slot_t [DEPTH-1:0] slot_q, slot_d;
  logic [SELW-1:0]       asel_q, asel_d, bsel_q, bsel_d;
  fwd_slot_t             id_entry;

  logic            rs_hit, rt_hit, rs_nr, rt_nr;
  logic [SELW-1:0] rs_sel, rt_sel;

  assign id_entry = '{valid: id_wen && (id_dst != '0), dst: id_dst, is_load: id_load};

  fwd_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SELW(SELW)) u_match_rs (
    .slots(slot_q), .rreg(id_rs), .use_r(id_use_rs),
    .hit(rs_hit), .sel(rs_sel), .not_ready(rs_nr)
  );

  fwd_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SELW(SELW)) u_match_rt (
    .slots(slot_q), .rreg(id_rt), .use_r(id_use_rt),
    .hit(rt_hit), .sel(rt_sel), .not_ready(rt_nr)
  );

  assign stall = rs_nr | rt_nr;

  always_comb begin
    slot_d = slot_q;
    asel_d = asel_q;
    bsel_d = bsel_q;
    if (pipe_en) begin
      for (int k = DEPTH-1; k > 0; k--) slot_d[k] = slot_q[k-1];
      // Flush and bubble both inject an empty EX slot with regfile selects.
      if (flush || stall) begin
        slot_d[0] = '0;
        asel_d    = '0;
        bsel_d    = '0;
      end else begin
        slot_d[0] = id_entry;
        asel_d    = rs_hit ? rs_sel : '0;
        bsel_d    = rt_hit ? rt_sel : '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      slot_q <= '0;
      asel_q <= '0;
      bsel_q <= '0;
    end else begin
      slot_q <= slot_d;
      asel_q <= asel_d;
      bsel_q <= bsel_d;
    end
  end

  assign ex_asel = asel_q;
  assign ex_bsel = bsel_q;

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (pipe_en && stall && !flush && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign stall_cycles = cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and load-use hazard unit for the pipelined MIPS core. It tracks in-flight register writers in a DEPTH-slot shift scoreboard (slot 0 = EX, slot k = k stages after EX). It computes EX-stage operand forward selects one cycle early, registering them as the instruction enters EX. It raises stall when a load result would not be ready in time. It replaces purely combinational forwarding and generalises to deeper MEM pipelines and longer load latency.

Parameters:
DEPTH, 3, number of tracked slots (EX..WB); legal 3..8
LOAD_LAT, 1, extra slots after MEM before load data is forwardable; legal 1..DEPTH-2
SELW, $clog2(DEPTH), width of forward select (derived; not overridden)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
pipe_en  in  1  global pipeline advance (memory/cache ready)
flush  in  1  kill instruction leaving ID (branch/jump resolve)
id_rs  in  5  ID-stage rs (regbits_t)
id_rt  in  5  ID-stage rt
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_wen  in  1  ID instruction writes a register
id_dst  in  5  ID destination (rd for R-type, rt for I-type, 31 for JAL)
id_load  in  1  ID instruction is LW/LL
stall  out  1  hold PC and IF/ID; bubble into EX
ex_asel  out  SELW  EX busA select: 0 = regfile, k = slot k result
ex_bsel  out  SELW  EX busB select, same encoding
stall_cycles  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset (nRST low, async): all slot valid bits = 0, ex_asel = ex_bsel = 0, stall_cycles = 0. stall falls to 0 immediately, because stall is combinational from cleared slots.
- Slot entry fields: {valid, dst, is_load}. An entry is valid only if id_wen=1 and id_dst != 0.
- Ready slot of an entry: 1 for non-load; 1+LOAD_LAT for load.
- Match for operand r (used, r != 0): the youngest valid slot j (lowest index) with dst == r. Older matches are ignored.
- Forward source after advance = j+1. If j+1 > DEPTH-1, no match: the regfile write-through supplies the value, sel = 0.
- stall (combinational) = 1 if either used operand's youngest match has j+1 < ready slot. A non-ready youngest match never falls back to an older slot.
- On the clock edge with pipe_en=1:
  - Shift: slot[k] <= slot[k-1] for k >= 1; slot DEPTH-1 drops off.
  - flush=1: slot0 <= invalid; ex_asel = ex_bsel <= 0. flush overrides stall.
  - else if stall=1: slot0 <= invalid (bubble); selects <= 0.
  - else: slot0 <= ID entry; selects <= computed j+1 (or 0).
- pipe_en=0: all state and selects hold. stall keeps being evaluated against the held state.
- Latency: selects valid for exactly the cycle(s) the instruction occupies EX. The load-use stall lasts LOAD_LAT cycles of pipe_en=1.
- id_use_* = 0 or register 0: never forwards, never stalls.
- An ID instruction writing and reading the same register: lookup uses pre-shift slots only. The instruction itself is not a producer for its own operands.

Optional Feature:
Macro FWD_HAZARD_PERF_EN.
- Defined: stall_cycles increments on each edge where pipe_en && stall && !flush. Saturates at 32'hFFFFFFFF. Cleared only by reset.
- Undefined: no counter flops; stall_cycles is tied to 0. The port always exists.

Decomposition:
- Package fwd_hazard_pkg (imports cpu_types_pkg): typedef fwd_slot_t {logic valid; regbits_t dst; logic is_load;}, localparam READY_ALU = 1, function ready_slot(is_load, LOAD_LAT).
- Sub-module fwd_match (combinational, parametrised DEPTH):
  - Inputs: slot array, register, use.
  - Outputs: hit, sel[SELW-1:0], not_ready.
  - Instantiated twice (rs, rt).
- Top holds the slot shift register, select registers, stall OR, and the perf counter.

Test Plan (DEPTH=3, LOAD_LAT=1 unless stated):
- ADD $3 then ADD $5,$3,$3 back-to-back, pipe_en=1 -> stall=0; next cycle ex_asel=1, ex_bsel=1.
- LW $4 then ADD $5,$4,$0 -> stall=1 for one cycle, slot0 bubble; next EX cycle ex_asel=2, ex_bsel=0.
- ADD $3; ADDI $3,$3,1; SUB $6,$3,$7 -> SUB gets ex_asel=1 (youngest), not 2; ex_bsel=0.
- Writer to $0 then reader of $0 -> stall=0, selects 0. pipe_en=0 during LW-ADD stall for 4 cycles -> stall held at 1, slots unchanged; one cycle after release, ex_asel=2.
- flush asserted during an active load-use stall -> stall ignored, slot0 invalid, selects 0. With FWD_HAZARD_PERF_EN, stall_cycles not incremented on that edge.
- DEPTH=5, LOAD_LAT=3: LW $8 then use $8 -> 3 stall cycles then ex_asel=4. nRST low mid-sequence -> stall=0 immediately, selects 0, counter 0.
